// File: rtl/insn_enc_if.sv
// rtl/insn_enc_if.sv - request/response bundle between an encode client and insn_enc.
interface insn_enc_if #(
    parameter int DWIDTH = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [DWIDTH-1:0] imm_i;
    logic              insn_valid_o;
    logic              insn_ready_i;
    logic [DWIDTH-1:0] insn_o;
    logic              err_o;
    logic [15:0]       count_o;

    modport master (
        output req_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, insn_ready_i,
        input  req_ready_o, insn_valid_o, insn_o, err_o, count_o
    );

    modport slave (
        input  req_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, insn_ready_i,
        output req_ready_o, insn_valid_o, insn_o, err_o, count_o
    );
endinterface

// File: rtl/insn_enc.sv
// rtl/insn_enc.sv - RV32 instruction field packer feeding a small output FIFO.
// Optional immediate range checking is enabled by defining INSN_ENC_RANGE_CHECK_EN.
module insn_enc #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input logic       clk,
    input logic       reset,
    insn_enc_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD
    } fmt_e;

    logic [6:0]        op;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DWIDTH-1:0] imm;
    logic [31:0]       enc;
    fmt_e              fmt;
    logic              enc_err;

    assign op  = bus.opcode_i;
    assign rd  = bus.rd_i;
    assign rs1 = bus.rs1_i;
    assign rs2 = bus.rs2_i;
    assign f3  = bus.funct3_i;
    assign f7  = bus.funct7_i;
    assign imm = bus.imm_i;

    always_comb begin
        enc = 32'h0000_0013;
        fmt = F_BAD;
        case (op)
            7'b0110011: begin
                fmt = F_R;
                enc = {f7, rs2, rs1, f3, rd, op};
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) begin
                    fmt = F_SH;
                    enc = {f7, imm[4:0], rs1, f3, rd, op};
                end else begin
                    fmt = F_I;
                    enc = {imm[11:0], rs1, f3, rd, op};
                end
            end
            7'b0100011: begin
                fmt = F_S;
                enc = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            7'b1100011: begin
                fmt = F_B;
                enc = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            7'b0110111, 7'b0010111: begin
                fmt = F_U;
                enc = {imm[31:12], rd, op};
            end
            7'b1101111: begin
                fmt = F_J;
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            default: begin
                fmt = F_BAD;
                enc = 32'h0000_0013;
            end
        endcase
    end

`ifdef INSN_ENC_RANGE_CHECK_EN
    localparam logic signed [DWIDTH-1:0] I_MIN = -2048;
    localparam logic signed [DWIDTH-1:0] I_MAX = 2047;
    localparam logic signed [DWIDTH-1:0] B_MIN = -4096;
    localparam logic signed [DWIDTH-1:0] B_MAX = 4094;
    localparam logic signed [DWIDTH-1:0] J_MIN = -1048576;
    localparam logic signed [DWIDTH-1:0] J_MAX = 1048574;

    logic signed [DWIDTH-1:0] imm_s;
    logic                     range_err;

    assign imm_s = imm;

    // The instruction is still packed from truncated bits; only the flag changes.
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            F_I, F_S: range_err = (imm_s < I_MIN) || (imm_s > I_MAX);
            F_SH:     range_err = |imm[DWIDTH-1:5];
            F_B:      range_err = (imm_s < B_MIN) || (imm_s > B_MAX) || imm[0];
            F_J:      range_err = (imm_s < J_MIN) || (imm_s > J_MAX) || imm[0];
            F_U:      range_err = |imm[11:0];
            default:  range_err = 1'b0;
        endcase
    end

    assign enc_err = (fmt == F_BAD) || range_err;
`else
    assign enc_err = (fmt == F_BAD);
`endif

    logic [DWIDTH-1:0] insn_mem [DEPTH];
    logic              err_mem  [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       occ_q, occ_d;
    logic [15:0]       count_q, count_d;
    logic              full, empty, push, pop;

    assign full  = (occ_q == (AW+1)'(DEPTH));
    assign empty = (occ_q == '0);
    assign push  = bus.req_valid_i && bus.req_ready_o;
    assign pop   = !empty && bus.insn_ready_i;

    // Ready is gated by the raw reset so it drops without waiting for a clock.
    assign bus.req_ready_o  = !reset && !full;
    assign bus.insn_valid_o = !empty;
    assign bus.insn_o       = empty ? '0 : insn_mem[rd_ptr_q];
    assign bus.err_o        = empty ? 1'b0 : err_mem[rd_ptr_q];
    assign bus.count_o      = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = push ? count_q + 16'd1 : count_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            insn_mem[wr_ptr_q] <= DWIDTH'(enc);
            err_mem[wr_ptr_q]  <= enc_err;
        end
    end
endmodule

// File: tb/tb_insn_enc.sv
// tb/tb_insn_enc.sv - directed-vector bench for insn_enc.
module tb_insn_enc;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    insn_enc_if #(.DWIDTH(32)) bus ();

    insn_enc #(.DWIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        bus.opcode_i = op;
        bus.rd_i     = rd;
        bus.rs1_i    = rs1;
        bus.rs2_i    = rs2;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        bus.imm_i    = imm;
    endtask

    localparam int NV = 8;
    logic [6:0]  v_op  [NV];
    logic [4:0]  v_rd  [NV];
    logic [4:0]  v_rs1 [NV];
    logic [4:0]  v_rs2 [NV];
    logic [2:0]  v_f3  [NV];
    logic [6:0]  v_f7  [NV];
    logic [31:0] v_imm [NV];
    logic [31:0] v_exp [NV];
    logic        v_err [NV];
    string       v_tag [NV];

    task automatic load_vec(input int i, input string tag, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp,
                            input logic err);
        v_tag[i] = tag; v_op[i] = op; v_rd[i] = rd; v_rs1[i] = rs1; v_rs2[i] = rs2;
        v_f3[i] = f3; v_f7[i] = f7; v_imm[i] = imm; v_exp[i] = exp; v_err[i] = err;
    endtask

    initial begin
        logic big_imm_err;
`ifdef INSN_ENC_RANGE_CHECK_EN
        big_imm_err = 1'b1;
`else
        big_imm_err = 1'b0;
`endif
        n_tests = 0;
        n_fail  = 0;
        load_vec(0, "addi",     7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,          32'h0050_0093, 1'b0);
        load_vec(1, "sw",       7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,          32'h0020_A423, 1'b0);
        load_vec(2, "beq",      7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0);
        load_vec(3, "jal",      7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8,          32'h0080_00EF, 1'b0);
        load_vec(4, "lui",      7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        load_vec(5, "srai",     7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd3,          32'h4030_D093, 1'b0);
        load_vec(6, "addi4096", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096,       32'h0000_0093, big_imm_err);
        load_vec(7, "badop",    7'b1111111, 5'd3, 5'd4, 5'd5, 3'b111, 7'h7F, 32'h0000_0123, 32'h0000_0013, 1'b1);

        reset            = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.insn_ready_i = 1'b0;
        set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        #12;
        check("rst_valid", {31'd0, bus.insn_valid_o}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready_o}, 32'd0);
        check("rst_insn",  bus.insn_o, 32'd0);
        check("rst_err",   {31'd0, bus.err_o}, 32'd0);
        check("rst_count", {16'd0, bus.count_o}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, bus.req_ready_o}, 32'd1);

        // Backpressure: two accepts fill the FIFO, third request stalls.
        @(posedge clk); #1;
        set_req(v_op[0], v_rd[0], v_rs1[0], v_rs2[0], v_f3[0], v_f7[0], v_imm[0]);
        bus.req_valid_i = 1'b1;
        @(posedge clk); #1;
        check("bp_head_a", bus.insn_o, v_exp[0]);
        set_req(v_op[1], v_rd[1], v_rs1[1], v_rs2[1], v_f3[1], v_f7[1], v_imm[1]);
        @(posedge clk); #1;
        check("bp_full_ready", {31'd0, bus.req_ready_o}, 32'd0);
        check("bp_head_a2", bus.insn_o, v_exp[0]);
        set_req(v_op[3], v_rd[3], v_rs1[3], v_rs2[3], v_f3[3], v_f7[3], v_imm[3]);
        @(posedge clk); #1;
        check("bp_head_held", bus.insn_o, v_exp[0]);
        check("bp_count2", {16'd0, bus.count_o}, 32'd2);
        bus.insn_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_head_b", bus.insn_o, v_exp[1]);
        check("bp_ready_again", {31'd0, bus.req_ready_o}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("bp_head_c", bus.insn_o, v_exp[3]);
        check("bp_count3", {16'd0, bus.count_o}, 32'd3);
        @(posedge clk); #1;
        check("bp_drained", {31'd0, bus.insn_valid_o}, 32'd0);
        check("bp_empty_insn", bus.insn_o, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            set_req(v_op[i], v_rd[i], v_rs1[i], v_rs2[i], v_f3[i], v_f7[i], v_imm[i]);
            bus.req_valid_i = 1'b1;
            @(posedge clk); #1;
            bus.req_valid_i = 1'b0;
            check({v_tag[i], "_valid"}, {31'd0, bus.insn_valid_o}, 32'd1);
            check({v_tag[i], "_insn"},  bus.insn_o, v_exp[i]);
            check({v_tag[i], "_err"},   {31'd0, bus.err_o}, {31'd0, v_err[i]});
            check({v_tag[i], "_count"}, {16'd0, bus.count_o}, 32'(4 + i));
        end
        @(posedge clk); #1;
        check("vec_drained", {31'd0, bus.insn_valid_o}, 32'd0);

        // Asynchronous reset with two entries queued.
        bus.insn_ready_i = 1'b0;
        set_req(v_op[4], v_rd[4], v_rs1[4], v_rs2[4], v_f3[4], v_f7[4], v_imm[4]);
        bus.req_valid_i = 1'b1;
        @(posedge clk); #1;
        set_req(v_op[5], v_rd[5], v_rs1[5], v_rs2[5], v_f3[5], v_f7[5], v_imm[5]);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check("pre_rst_full", {31'd0, bus.req_ready_o}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.insn_valid_o}, 32'd0);
        check("arst_count", {16'd0, bus.count_o}, 32'd0);
        check("arst_insn",  bus.insn_o, 32'd0);
        check("arst_ready", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_ready_after", {31'd0, bus.req_ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
